// File: rtl/card_dealer_pkg.sv
`default_nettype none
// ============================================================================
// card_dealer_pkg : shared constants, FSM state encoding and card encoder
// Revision       : 1.0
// ============================================================================
package card_dealer_pkg;

    localparam int          DECK_SIZE = 52;
    localparam int          RANKS     = 13;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAW  = 3'd1,
        ST_PROBE = 3'd2,
        ST_DEAL  = 3'd3,
        ST_EMPTY = 3'd4
    } state_e;

    // Index 0..51 -> {2'b00, suit, rank}; compare ladder avoids a divider.
    function automatic logic [7:0] encode_card(input logic [5:0] idx);
        logic [1:0] suit;
        logic [5:0] base;
        if (idx >= 6'(3 * RANKS)) begin
            suit = 2'd3;
            base = 6'(3 * RANKS);
        end else if (idx >= 6'(2 * RANKS)) begin
            suit = 2'd2;
            base = 6'(2 * RANKS);
        end else if (idx >= 6'(RANKS)) begin
            suit = 2'd1;
            base = 6'(RANKS);
        end else begin
            suit = 2'd0;
            base = 6'd0;
        end
        return {2'b00, suit, 4'(idx - base) + 4'd1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/card_lfsr_dp.sv
`default_nettype none
// ============================================================================
// card_lfsr_dp : free-running right-shifting Galois LFSR, seeded on reset
// Revision     : 1.0
// ============================================================================
module card_lfsr_dp #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] MASK  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    output logic [WIDTH-1:0] lfsr_o
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[WIDTH-1:1]} ^ (lfsr_q[0] ? MASK : '0);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/card_dealer_dp.sv
`default_nettype none
// ============================================================================
// card_dealer_dp : multi-deck shoe dealer with LFSR draw and linear probing
// Revision       : 1.0
// ============================================================================
module card_dealer_dp
    import card_dealer_pkg::*;
#(
    parameter int          NUM_DECKS = 1,
    parameter logic [15:0] SEED      = 16'hACE1,
    localparam int         CNT_W     = $clog2(NUM_DECKS + 1),
    localparam int         LEFT_W    = $clog2(DECK_SIZE * NUM_DECKS + 1)
) (
    input  logic              clk_dp_i,
    input  logic              rst_n_dp_i,
    input  logic              req_card_state_dp,
    input  logic              shuffle_dp_i,
    output logic [7:0]        card_to_send_dp,
    output logic              card_valid_dp,
    output logic              busy_dp,
    output logic              deck_empty_dp,
    output logic [LEFT_W-1:0] cards_left_dp
);

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(NUM_DECKS);
    localparam logic [LEFT_W-1:0] SHOE_SIZE = LEFT_W'(DECK_SIZE * NUM_DECKS);
    localparam logic [5:0]        LAST_IDX  = 6'(DECK_SIZE - 1);

    state_e             state_q;
    state_e             state_d;
    logic               req_q;
    logic [5:0]         cand_q;
    logic [CNT_W-1:0]   count_q [DECK_SIZE];
    logic [LEFT_W-1:0]  left_q;
    logic [7:0]         card_q;

    logic [15:0]        w_lfsr;
    logic [9:0]         w_lfsr_unused;
    logic [5:0]         w_draw_idx;
    logic [5:0]         w_sel_idx;
    logic [5:0]         w_next_idx;
    logic               w_req_rise;
    logic               w_sel_avail;
    logic               w_deal_load;
    logic               w_probe_load;

    card_lfsr_dp #(
        .WIDTH (16),
        .MASK  (LFSR_MASK),
        .SEED  (SEED)
    ) u_lfsr (
        .clk_i   (clk_dp_i),
        .rst_n_i (rst_n_dp_i),
        .lfsr_o  (w_lfsr)
    );

    // Only the low six bits pick a card; the fold-back of 52..63 is a known bias.
    assign w_lfsr_unused = w_lfsr[15:6];
    assign w_draw_idx    = (w_lfsr[5:0] >= 6'(DECK_SIZE)) ? (w_lfsr[5:0] - 6'(DECK_SIZE))
                                                          : w_lfsr[5:0];
    assign w_sel_idx     = (state_q == ST_DRAW) ? w_draw_idx : cand_q;
    assign w_next_idx    = (w_sel_idx == LAST_IDX) ? 6'd0 : (w_sel_idx + 6'd1);
    assign w_sel_avail   = (count_q[w_sel_idx] < FULL_CNT);
    assign w_req_rise    = req_card_state_dp & ~req_q;

    always_ff @(posedge clk_dp_i or negedge rst_n_dp_i) begin
        if (!rst_n_dp_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        w_deal_load  = 1'b0;
        w_probe_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_req_rise && (left_q != '0)) begin
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW, ST_PROBE: begin
                if (w_sel_avail) begin
                    state_d     = ST_DEAL;
                    w_deal_load = 1'b1;
                end else begin
                    state_d      = ST_PROBE;
                    w_probe_load = 1'b1;
                end
            end
            ST_DEAL: begin
                state_d = (left_q == '0) ? ST_EMPTY : ST_IDLE;
            end
            ST_EMPTY: begin
                state_d = ST_EMPTY;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Shuffle overrides everything, including a same-cycle request or deal.
        if (shuffle_dp_i) begin
            state_d      = ST_IDLE;
            w_deal_load  = 1'b0;
            w_probe_load = 1'b0;
        end
    end

    // Card, counter and remaining count all update on entry to DEAL so they
    // are already visible during the strobe cycle.
    always_ff @(posedge clk_dp_i or negedge rst_n_dp_i) begin
        if (!rst_n_dp_i) begin
            req_q  <= 1'b0;
            cand_q <= 6'd0;
            left_q <= SHOE_SIZE;
            card_q <= 8'd0;
            for (int i = 0; i < DECK_SIZE; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            req_q <= req_card_state_dp;
            if (shuffle_dp_i) begin
                left_q <= SHOE_SIZE;
                for (int i = 0; i < DECK_SIZE; i++) begin
                    count_q[i] <= '0;
                end
            end else if (w_deal_load) begin
                count_q[w_sel_idx] <= count_q[w_sel_idx] + CNT_W'(1);
                left_q             <= left_q - LEFT_W'(1);
                card_q             <= encode_card(w_sel_idx);
            end
            if (w_probe_load) begin
                cand_q <= w_next_idx;
            end
        end
    end

    assign card_to_send_dp = card_q;
    assign card_valid_dp   = (state_q == ST_DEAL);
    assign busy_dp         = (state_q == ST_DRAW) || (state_q == ST_PROBE) || (state_q == ST_DEAL);
    assign deck_empty_dp   = (left_q == '0);
    assign cards_left_dp   = left_q;

endmodule
`default_nettype wire
